// File: rtl/dmem_port.sv
// -----------------------------------------------------------------------------
// dmem_port
//
// Single-port data memory that responds to the load/store path with a
// valid/ready request/response handshake and a fixed access latency.
// A request is captured in IDLE, waits WAIT_CYCLES cycles in WAIT, and the
// memory access happens on the edge that enters RESP. The response is held
// until the initiator accepts it.
//
// Parameters
//   WIDTH_ADDR   word-index bits, depth = 2**WIDTH_ADDR words
//   WIDTH_DATA   data word width, multiple of 8
//   WAIT_CYCLES  wait states between accept and response (0 allowed)
//
// Ports
//   clk        in   clock, all state on rising edge
//   reset      in   asynchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  responder can accept a request (high only in IDLE)
//   req_we     in   1 = store, 0 = load
//   req_addr   in   byte address; bits above the word index are ignored
//   req_wdata  in   store data
//   req_be     in   store byte enables, bit i covers byte lane i
//   rsp_valid  out  response present (high only in RESP)
//   rsp_ready  in   initiator accepts the response
//   rsp_rdata  out  load data; 0 for stores and misaligned requests
//   rsp_err    out  request address was not word aligned
// -----------------------------------------------------------------------------
module dmem_port #(
    parameter int WIDTH_ADDR  = 6,
    parameter int WIDTH_DATA  = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [31:0]             req_addr,
    input  logic [WIDTH_DATA-1:0]   req_wdata,
    input  logic [WIDTH_DATA/8-1:0] req_be,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH_DATA-1:0]   rsp_rdata,
    output logic                    rsp_err
);

    localparam int DEPTH  = 2 ** WIDTH_ADDR;
    localparam int NBYTES = WIDTH_DATA / 8;
    localparam int AW     = WIDTH_ADDR + 2;   // byte address bits actually used
    localparam int CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;

    // Captured request
    logic                we_q;
    logic [AW-1:0]       addr_q;
    logic [WIDTH_DATA-1:0] wdata_q;
    logic [NBYTES-1:0]   be_q;

    logic                accept;
    logic                do_access;

    // Values seen by the memory on the access edge
    logic                acc_we;
    logic [AW-1:0]       acc_addr;
    logic [WIDTH_DATA-1:0] acc_wdata;
    logic [NBYTES-1:0]   acc_be;
    logic [WIDTH_ADDR-1:0] acc_idx;
    logic                acc_misaligned;
    logic                mem_we;

    logic [WIDTH_DATA-1:0] mem [DEPTH];

    // Upper address bits intentionally alias onto the word array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:AW];

    // -------------------------------------------------------------------------
    // FSM: state register and wait counter
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Request capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr[AW-1:0];
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    // -------------------------------------------------------------------------
    // Memory access on the edge entering RESP. With zero wait states that edge
    // is the accept edge itself, so the live request is used instead of the
    // captured copy.
    // -------------------------------------------------------------------------
    assign do_access = (state != RESP) && (state_next == RESP);

    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_be    = be_q;
        if (state == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr[AW-1:0];
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end
    end

    assign acc_idx        = acc_addr[AW-1:2];
    assign acc_misaligned = (acc_addr[1:0] != 2'b00);
    // Gate on reset so a store racing an asserted reset never commits.
    assign mem_we         = do_access && acc_we && !acc_misaligned && !reset;

    // NOTE: the storage array has no reset; contents are undefined until
    // written, which keeps it mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response registers: loaded on the access edge, held through RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (do_access) begin
            rsp_err <= acc_misaligned;
            if (acc_misaligned || acc_we) begin
                rsp_rdata <= '0;
            end else begin
                rsp_rdata <= mem[acc_idx];
            end
        end
    end

endmodule

// File: tb/tb_dmem_port.sv
// -----------------------------------------------------------------------------
// tb_dmem_port
//
// Self-checking bench for dmem_port. Instance 0 uses the default latency
// (WAIT_CYCLES=2) and runs a table of directed load/store vectors plus
// hand-written sequences for back-pressure and reset in WAIT/RESP.
// Instance 1 uses WAIT_CYCLES=0 to cover the minimum latency and wrap.
// -----------------------------------------------------------------------------
module tb_dmem_port;

    localparam int WC0 = 2;
    localparam int WC1 = 0;

    logic        clk = 1'b0;
    logic        reset     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    dmem_port #(.WIDTH_ADDR(6), .WIDTH_DATA(32), .WAIT_CYCLES(WC0)) dut0 (
        .clk       (clk),
        .reset     (reset[0]),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_we    (req_we[0]),
        .req_addr  (req_addr[0]),
        .req_wdata (req_wdata[0]),
        .req_be    (req_be[0]),
        .rsp_valid (rsp_valid[0]),
        .rsp_ready (rsp_ready[0]),
        .rsp_rdata (rsp_rdata[0]),
        .rsp_err   (rsp_err[0])
    );

    dmem_port #(.WIDTH_ADDR(6), .WIDTH_DATA(32), .WAIT_CYCLES(WC1)) dut1 (
        .clk       (clk),
        .reset     (reset[1]),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_we    (req_we[1]),
        .req_addr  (req_addr[1]),
        .req_wdata (req_wdata[1]),
        .req_be    (req_be[1]),
        .rsp_valid (rsp_valid[1]),
        .rsp_ready (rsp_ready[1]),
        .rsp_rdata (rsp_rdata[1]),
        .rsp_err   (rsp_err[1])
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One complete transaction with rsp_ready held high. Returns the response
    // and the number of cycles from the accept cycle to rsp_valid.
    task automatic xact(input int s, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] rdata, output logic err, output int lat);
        int n;
        @(negedge clk);
        req_we[s]    = we;
        req_addr[s]  = addr;
        req_wdata[s] = wdata;
        req_be[s]    = be;
        req_valid[s] = 1'b1;
        rsp_ready[s] = 1'b1;
        n = 0;
        while (!req_ready[s] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[s]) begin
            check("req_ready_timeout", 32'(req_ready[s]), 32'd1);
        end
        @(posedge clk);
        #1;
        req_valid[s] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid[s] && lat < 20);
        rdata = rsp_rdata[s];
        err   = rsp_err[s];
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int s, input string name);
        int n;
        n = 0;
        while (!rsp_valid[s] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid[s]) begin
            check(name, 32'(rsp_valid[s]), 32'd1);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0020, 32'h11223344, 4'hF, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABBCCDD, 4'h5, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'hF, 32'h11BB33DD, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0022, 32'hCAFEF00D, 4'hF, 32'h0000_0000, 1'b1};
        vecs[6]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'h0, 32'h11BB33DD, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_0023, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b1, 32'h0000_0020, 32'hFFFFFFFF, 4'h0, 32'h0000_0000, 1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'h0, 32'h11BB33DD, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_0100, 32'h0000_0005, 4'hF, 32'h0000_0000, 1'b0};
        vecs[11] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'h0000_0005, 1'b0};
        vecs[12] = '{1'b1, 32'h0000_00FC, 32'h12345678, 4'hF, 32'h0000_0000, 1'b0};
        vecs[13] = '{1'b0, 32'h0000_03FC, 32'h0000_0000, 4'h0, 32'h12345678, 1'b0};

        for (int s = 0; s < 2; s++) begin
            reset[s]     = 1'b1;
            req_valid[s] = 1'b0;
            req_we[s]    = 1'b0;
            req_addr[s]  = '0;
            req_wdata[s] = '0;
            req_be[s]    = '0;
            rsp_ready[s] = 1'b0;
        end

        // ---- Reset values ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("rst%0d_req_ready", s), 32'(req_ready[s]), 32'd1);
            check($sformatf("rst%0d_rsp_valid", s), 32'(rsp_valid[s]), 32'd0);
            check($sformatf("rst%0d_rsp_rdata", s), rsp_rdata[s], 32'd0);
            check($sformatf("rst%0d_rsp_err", s), 32'(rsp_err[s]), 32'd0);
            reset[s] = 1'b0;
        end

        // ---- Table-driven vectors on the WAIT_CYCLES=2 instance ----
        for (int i = 0; i < NVEC; i++) begin
            xact(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(WC0 + 1));
        end

        // ---- Back-pressure with a competing request ----
        @(negedge clk);
        req_we[0] = 1'b0; req_addr[0] = 32'h10; req_be[0] = 4'h0;
        req_valid[0] = 1'b1;
        rsp_ready[0] = 1'b0;
        @(posedge clk);
        #1;
        // Accepted on that edge; keep offering a different load meanwhile.
        req_addr[0] = 32'h20;
        @(negedge clk);
        wait_rsp(0, "bp_rsp_timeout");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_rsp_valid", i), 32'(rsp_valid[0]), 32'd1);
            check($sformatf("bp%0d_rsp_rdata", i), rsp_rdata[0], 32'hDEADBEEF);
            check($sformatf("bp%0d_req_ready", i), 32'(req_ready[0]), 32'd0);
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("bp_release_req_ready", 32'(req_ready[0]), 32'd1);
        check("bp_release_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("bp_no_phantom%0d", i), 32'(rsp_valid[0]), 32'd0);
        end

        // ---- Reset during WAIT drops a pending store ----
        xact(0, 1'b1, 32'h30, 32'h1, 4'hF, rd, er, lat);
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        check("pre_rst_load", rd, 32'hDEADBEEF);
        @(negedge clk);
        req_we[0] = 1'b1; req_addr[0] = 32'h30; req_wdata[0] = 32'h77; req_be[0] = 4'hF;
        req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("wait_state_req_ready", 32'(req_ready[0]), 32'd0);
        reset[0] = 1'b1;
        #1;
        check("rst_wait_req_ready", 32'(req_ready[0]), 32'd1);
        check("rst_wait_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("rst_wait_rsp_rdata", rsp_rdata[0], 32'd0);
        check("rst_wait_rsp_err", 32'(rsp_err[0]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset[0] = 1'b0;
        xact(0, 1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
        check("rst_wait_store_dropped", rd, 32'h1);

        // ---- Reset during RESP keeps a committed store ----
        @(negedge clk);
        req_we[0] = 1'b1; req_addr[0] = 32'h34; req_wdata[0] = 32'h9; req_be[0] = 4'hF;
        req_valid[0] = 1'b1;
        rsp_ready[0] = 1'b0;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        wait_rsp(0, "resp_rst_timeout");
        reset[0] = 1'b1;
        #1;
        check("rst_resp_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        @(negedge clk);
        reset[0] = 1'b0;
        xact(0, 1'b0, 32'h34, 32'h0, 4'h0, rd, er, lat);
        check("rst_resp_store_kept", rd, 32'h9);

        // ---- Zero wait states: wrap and 1-cycle response ----
        xact(1, 1'b1, 32'h100, 32'h5, 4'hF, rd, er, lat);
        check("wc0_store_rdata", rd, 32'd0);
        check("wc0_store_latency", 32'(lat), 32'(WC1 + 1));
        xact(1, 1'b0, 32'h000, 32'h0, 4'h0, rd, er, lat);
        check("wc0_load_rdata", rd, 32'h5);
        check("wc0_load_err", 32'(er), 32'd0);
        check("wc0_load_latency", 32'(lat), 32'(WC1 + 1));
        @(negedge clk);
        check("wc0_idle_req_ready", 32'(req_ready[1]), 32'd1);
        xact(1, 1'b0, 32'h102, 32'h0, 4'h0, rd, er, lat);
        check("wc0_misaligned_err", 32'(er), 32'd1);
        check("wc0_misaligned_rdata", rd, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, limit 200000");
        $fatal(1, "timeout");
    end

endmodule
